// File: rtl/light_timer_if.sv
// Timer request/response bundle between the traffic-light FSM (master) and
// the countdown timer (slave).
interface light_timer_if;
   // Handshake: t_start is a one-cycle request with no ready; the timer always
   // accepts it on the edge it is seen. t_length is valid only with t_start.
   // t_freeze is a level. t_done/t_flicker are one-cycle pulses.
   // t_remaining/t_busy are level status.
   logic       t_start;
   logic [4:0] t_length;
   logic       t_freeze;
   logic       t_done;
   logic       t_flicker;
   logic [4:0] t_remaining;
   logic       t_busy;

   modport master (
      output t_start, t_length, t_freeze,
      input  t_done, t_flicker, t_remaining, t_busy
   );

   modport slave (
      input  t_start, t_length, t_freeze,
      output t_done, t_flicker, t_remaining, t_busy
   );
endinterface

// File: rtl/light_timer.sv
// Countdown timer for the traffic-light controller: prescaled unit countdown
// with expiry pulse, flicker pulses near the end, and freeze/restart support.
module light_timer #(
   parameter int         TICK_DIV       = 4,
   parameter logic [4:0] FLICKER_WINDOW = 5'd4
) (
   input  logic          clk,
   input  logic          reset,
   light_timer_if.slave  tif,
   output logic          state_dbg
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e        state;
   logic [PW-1:0] presc;
   logic [4:0]    count;
   logic          done;
   logic          flicker;
   logic          busy;

   logic [4:0]    count_dec;
   logic          unit_edge;

   // RUN always holds count >= 1, so the decrement never wraps.
   assign count_dec = count - 5'd1;
   assign unit_edge = (presc == PRESC_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         presc   <= '0;
         count   <= '0;
         done    <= 1'b0;
         flicker <= 1'b0;
         busy    <= 1'b0;
      end else begin
         done    <= 1'b0;
         flicker <= 1'b0;
         if (tif.t_start) begin
            count <= tif.t_length;
            presc <= '0;
            if (tif.t_length != 5'd0) begin
               state <= RUN;
               busy  <= 1'b1;
            end else begin
               // A zero-length run expires immediately.
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
         end else if (state == RUN && !tif.t_freeze) begin
            if (unit_edge) begin
               presc <= '0;
               count <= count_dec;
               if (count_dec == 5'd0) begin
                  done  <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (count_dec <= FLICKER_WINDOW) begin
                  flicker <= 1'b1;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end
      end
   end

   assign tif.t_done      = done;
   assign tif.t_flicker   = flicker;
   assign tif.t_remaining = count;
   assign tif.t_busy      = busy;
   assign state_dbg       = (state == RUN);

endmodule

// File: tb/tb_light_timer.sv
// Bench for light_timer: two instances (TICK_DIV=4/FW=4 and TICK_DIV=1/FW=0)
// checked against expected pulse edges and status samples held in queues.
module tb_light_timer;

   typedef struct {
      int e;
      int rem;
      int busy;
   } samp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic st0, st1;
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   int    done_q[2][$];
   int    flk_q[2][$];
   samp_t samp_q[2][$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   light_timer_if bus0 ();
   light_timer_if bus1 ();

   light_timer #(.TICK_DIV(4), .FLICKER_WINDOW(5'd4)) dut0 (
      .clk(clk), .reset(rst), .tif(bus0), .state_dbg(st0)
   );
   light_timer #(.TICK_DIV(1), .FLICKER_WINDOW(5'd0)) dut1 (
      .clk(clk), .reset(rst), .tif(bus1), .state_dbg(st1)
   );

   function automatic int td_of(input int id);
      return (id == 0) ? 4 : 1;
   endfunction

   function automatic int fw_of(input int id);
      return (id == 0) ? 4 : 0;
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_cnt, got, exp);
      end
   endtask

   task automatic push_sample(input int id, input int e, input int rem, input int busy);
      samp_t s;
      int i;
      s.e = e; s.rem = rem; s.busy = busy;
      i = 0;
      while (i < samp_q[id].size() && samp_q[id][i].e < e) i++;
      samp_q[id].insert(i, s);
   endtask

   // Drop every expectation at or after edge e (aborted run or reset).
   task automatic flush(input int id, input int e);
      for (int i = done_q[id].size() - 1; i >= 0; i--)
         if (done_q[id][i] >= e) done_q[id].delete(i);
      for (int i = flk_q[id].size() - 1; i >= 0; i--)
         if (flk_q[id][i] >= e) flk_q[id].delete(i);
      for (int i = samp_q[id].size() - 1; i >= 0; i--)
         if (samp_q[id][i].e >= e) samp_q[id].delete(i);
   endtask

   // Expected events of a run started at edge e0; freeze held on edges
   // e0+fz_off .. e0+fz_off+fz_n-1 delays every later unit boundary by fz_n.
   task automatic push_run(input int id, input int e0, input int len,
                           input int fz_off, input int fz_n);
      int td, fw, o, a;
      td = td_of(id);
      fw = fw_of(id);
      push_sample(id, e0, len, (len != 0) ? 1 : 0);
      if (len == 0) done_q[id].push_back(e0);
      for (int k = 1; k <= len; k++) begin
         o = td * k;
         a = o + ((fz_n > 0 && o >= fz_off) ? fz_n : 0);
         push_sample(id, e0 + a, len - k, (k < len) ? 1 : 0);
         if (k == len) done_q[id].push_back(e0 + a);
         else if (fw != 0 && (len - k) <= fw) flk_q[id].push_back(e0 + a);
      end
      for (int j = 0; j < fz_n; j++)
         push_sample(id, e0 + fz_off + j, len - (fz_off - 1) / td, 1);
   endtask

   task automatic set_start(input int id, input logic s, input int len);
      if (id == 0) begin
         bus0.t_start = s; bus0.t_length = 5'(len);
      end else begin
         bus1.t_start = s; bus1.t_length = 5'(len);
      end
   endtask

   task automatic set_freeze(input int id, input logic v);
      if (id == 0) bus0.t_freeze = v;
      else bus1.t_freeze = v;
   endtask

   // Called at a negedge; the start is seen on the next posedge.
   task automatic start_run(input int id, input int len, input int fz_off, input int fz_n);
      int e0;
      e0 = edge_cnt + 1;
      flush(id, e0);
      push_run(id, e0, len, fz_off, fz_n);
      set_start(id, 1'b1, len);
      @(negedge clk);
      set_start(id, 1'b0, 0);
   endtask

   task automatic mon(input int id, input logic d, input logic f, input logic [4:0] r,
                      input logic b, input logic s);
      bit ed, ef;
      samp_t sp;
      ed = (done_q[id].size() > 0 && done_q[id][0] == edge_cnt);
      check_eq($sformatf("t_done%0d", id), int'(d), int'(ed));
      if (ed) void'(done_q[id].pop_front());
      ef = (flk_q[id].size() > 0 && flk_q[id][0] == edge_cnt);
      check_eq($sformatf("t_flicker%0d", id), int'(f), int'(ef));
      if (ef) void'(flk_q[id].pop_front());
      while (samp_q[id].size() > 0 && samp_q[id][0].e <= edge_cnt) begin
         sp = samp_q[id].pop_front();
         check_eq($sformatf("sample_edge%0d", id), sp.e, edge_cnt);
         check_eq($sformatf("t_remaining%0d", id), int'(r), sp.rem);
         check_eq($sformatf("t_busy%0d", id), int'(b), sp.busy);
         check_eq($sformatf("state%0d", id), int'(s), sp.busy);
      end
   endtask

   always @(negedge clk) begin
      mon(0, bus0.t_done, bus0.t_flicker, bus0.t_remaining, bus0.t_busy, st0);
      mon(1, bus1.t_done, bus1.t_flicker, bus1.t_remaining, bus1.t_busy, st1);
   end

   initial begin
      int e0, len;
      set_start(0, 1'b0, 0); set_freeze(0, 1'b0);
      set_start(1, 1'b0, 0); set_freeze(1, 1'b0);
      for (int id = 0; id < 2; id++) begin
         push_sample(id, 1, 0, 0);
         push_sample(id, 2, 0, 0);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // L=3: remaining 3,2,1,0 at +0,+4,+8,+12; flicker at +4,+8; done at +12
      start_run(0, 3, 0, 0);
      repeat (14) @(negedge clk);

      // L=20 with 10 freeze cycles from +30: done at +90
      start_run(0, 20, 30, 10);
      repeat (29) @(negedge clk);
      set_freeze(0, 1'b1);
      repeat (10) @(negedge clk);
      set_freeze(0, 1'b0);
      repeat (55) @(negedge clk);

      // L=18 restarted with L=3 at +20: only the second run expires, at +32
      start_run(0, 18, 0, 0);
      repeat (19) @(negedge clk);
      start_run(0, 3, 0, 0);
      repeat (15) @(negedge clk);

      // restart on the very edge the run would expire
      start_run(0, 1, 0, 0);
      repeat (3) @(negedge clk);
      start_run(0, 2, 0, 0);
      repeat (10) @(negedge clk);

      // L=0: single done pulse, never busy
      start_run(0, 0, 0, 0);
      repeat (3) @(negedge clk);

      // freeze together with start: start wins, freeze holds the next 3 edges
      set_freeze(0, 1'b1);
      start_run(0, 2, 1, 3);
      repeat (3) @(negedge clk);
      set_freeze(0, 1'b0);
      repeat (12) @(negedge clk);

      // reset at +6 of an L=5 run, then idle freeze/length activity
      start_run(0, 5, 0, 0);
      e0 = edge_cnt;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      flush(0, e0 + 6);
      flush(1, e0 + 6);
      push_sample(0, e0 + 6, 0, 0);
      push_sample(1, e0 + 6, 0, 0);
      for (int j = 1; j <= 8; j++) push_sample(0, e0 + 6 + j, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      set_freeze(0, 1'b1);
      set_freeze(1, 1'b1);
      bus0.t_length = 5'd17;
      repeat (8) @(negedge clk);
      set_freeze(0, 1'b0);
      set_freeze(1, 1'b0);
      repeat (2) @(negedge clk);

      // TICK_DIV=1, no flicker: L=2 expires at +2; restart on +2 suppresses it
      start_run(1, 2, 0, 0);
      repeat (4) @(negedge clk);
      start_run(1, 2, 0, 0);
      @(negedge clk);
      start_run(1, 2, 0, 0);
      repeat (5) @(negedge clk);

      // random-length runs on the prescaled instance
      repeat (6) begin
         len = int'($urandom_range(1, 12));
         start_run(0, len, 0, 0);
         repeat (4 * len + int'($urandom_range(1, 4))) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      for (int id = 0; id < 2; id++) begin
         check_eq($sformatf("done_left%0d", id), done_q[id].size(), 0);
         check_eq($sformatf("flicker_left%0d", id), flk_q[id].size(), 0);
         check_eq($sformatf("samples_left%0d", id), samp_q[id].size(), 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
